dadda_mac_acc: RTL and testbench

//  Multiply-accumulate stage built around the combinational dadda_8x8 multiplier.

---
 rtl/dadda_mac_acc.sv | 200 ++++++++++++++++++++
 tb/tb_dadda_mac_acc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mac_acc.sv
// Multiply-accumulate stage: registered operands feed a Dadda-style 8x8
// multiplier, and the products are summed per burst with a sticky carry-out flag.

// Combinational 8x8 multiplier. Partial-product rows are reduced with
// carry-save 3:2 layers (8 -> 6 -> 4 -> 3 -> 2) before one final adder.
module dadda_8x8 (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_p
);

    function automatic logic [15:0] fa_s(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z
    );
        return x ^ y ^ z;
    endfunction

    // Carry bits are shifted up one column. A carry dropped off bit 15 is harmless:
    // the true product fits in 16 bits, so the result is still exact modulo 2^16.
    function automatic logic [15:0] fa_c(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z
    );
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [15:0] w_pp [8];
    logic [15:0] w_s10, w_c10, w_s11, w_c11;
    logic [15:0] w_s20, w_c20, w_s21, w_c21;
    logic [15:0] w_s30, w_c30;
    logic [15:0] w_s40, w_c40;

    // Partial-product row i is the multiplicand gated by multiplier bit i.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_pp[i] = i_b[i] ? ({8'd0, i_a} << i) : 16'd0;
        end
    end

    assign w_s10 = fa_s(w_pp[0], w_pp[1], w_pp[2]);
    assign w_c10 = fa_c(w_pp[0], w_pp[1], w_pp[2]);
    assign w_s11 = fa_s(w_pp[3], w_pp[4], w_pp[5]);
    assign w_c11 = fa_c(w_pp[3], w_pp[4], w_pp[5]);

    assign w_s20 = fa_s(w_s10, w_c10, w_s11);
    assign w_c20 = fa_c(w_s10, w_c10, w_s11);
    assign w_s21 = fa_s(w_c11, w_pp[6], w_pp[7]);
    assign w_c21 = fa_c(w_c11, w_pp[6], w_pp[7]);

    assign w_s30 = fa_s(w_s20, w_c20, w_s21);
    assign w_c30 = fa_c(w_s20, w_c20, w_s21);

    assign w_s40 = fa_s(w_s30, w_c30, w_c21);
    assign w_c40 = fa_c(w_s30, w_c30, w_c21);

    assign o_p = w_s40 + w_c40;

endmodule

// Burst multiply-accumulate with valid/ready on both the operand and result ports.
module dadda_mac_acc #(
    parameter int N     = 8,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_cnt,
    output logic             ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic               r_last;
    logic               r_v1;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [ACC_W-1:0]   r_acc_out;
    logic [CNT_W-1:0]   r_term_cnt;
    logic               r_ovf_out;

    logic [2*N-1:0]     w_p;
    logic [ACC_W:0]     w_sum;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ovf_nxt;
    logic               w_xfer;
    logic               w_final;

    dadda_8x8 u_mul (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_p)
    );

    // The bubble after a last beat keeps the next burst from merging into this one.
    assign in_ready  = !rst && (r_state == ACC) && !(r_v1 && r_last);
    assign w_xfer    = in_valid && in_ready;
    assign w_final   = r_v1 && r_last;

    assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(w_p);
    assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_ovf_nxt = r_ovf | w_sum[ACC_W];

    assign out_valid = (r_state == DONE);
    assign acc_out   = r_acc_out;
    assign term_cnt  = r_term_cnt;
    assign ovf       = r_ovf_out;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: close the burst on its final update, reopen on the result handshake.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ACC: begin
                if (w_final) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = ACC;
                end
            end
            default: w_state_nxt = ACC;
        endcase
    end

    // Stage 1: capture the operand beat on transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_last <= 1'b0;
            r_v1   <= 1'b0;
        end else begin
            r_v1 <= w_xfer;
            if (w_xfer) begin
                r_a    <= in_a;
                r_b    <= in_b;
                r_last <= in_last;
            end
        end
    end

    // Stage 2: accumulate; on the final beat publish the totals and restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_acc_out  <= '0;
            r_term_cnt <= '0;
            r_ovf_out  <= 1'b0;
        end else if (r_v1) begin
            if (r_last) begin
                r_acc_out  <= w_sum[ACC_W-1:0];
                r_term_cnt <= w_cnt_nxt;
                r_ovf_out  <= w_ovf_nxt;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_cnt <= w_cnt_nxt;
                r_ovf <= w_ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Directed and randomised bench for dadda_mac_acc.
// Expected results are queued as beats are sent and checked on each result handshake.

module tb_dadda_mac_acc;

    typedef struct {
        logic [23:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] acc_out;
    logic [7:0]  term_cnt;
    logic        ovf;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_push  = 0;
    int          n_pop   = 0;
    longint      m_sum   = 0;
    int          m_cnt   = 0;
    logic        rnd     = 1'b0;
    logic [23:0] last_acc;
    logic [7:0]  last_cnt;
    logic        last_ovf;

    dadda_mac_acc #(.N(8), .ACC_W(24), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .term_cnt  (term_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Must be entered just after a rising edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int t;
        exp_t e;
        t = 0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            tick();
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $error("FAIL send_timeout: observed in_ready=0 expected 1 within 500 cycles");
            tick();
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        m_sum += longint'(a) * longint'(b);
        m_cnt++;
        if (last) begin
            e.acc = m_sum[23:0];
            e.cnt = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
            e.ovf = (m_sum >= 64'd16777216);
            sb.push_back(e);
            n_push++;
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 1000) begin
            tick();
            t++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
        end
    endtask

    // Scoreboard: check each result at the handshake that consumes it.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_unexpected: observed result %0d expected none", acc_out);
            end else begin
                e = sb.pop_front();
                chk("sb_acc", 32'(acc_out), 32'(e.acc));
                chk("sb_cnt", 32'(term_cnt), 32'(e.cnt));
                chk("sb_ovf", 32'(ovf), 32'(e.ovf));
                last_acc = acc_out;
                last_cnt = term_cnt;
                last_ovf = ovf;
                n_pop++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_acc_out", 32'(acc_out), 0);
        chk("rst_term_cnt", 32'(term_cnt), 0);
        chk("rst_ovf", 32'(ovf), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        tick();

        // 1: single-beat burst, latency and handshake timing
        send(8'd15, 8'd17, 1'b1);
        @(negedge clk);
        chk("t1_valid_at_t1", 32'(out_valid), 0);
        tick();
        @(negedge clk);
        chk("t1_valid_at_t2", 32'(out_valid), 1);
        chk("t1_in_ready_done", 32'(in_ready), 0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t1_in_ready_after", 32'(in_ready), 1);
        chk("t1_valid_cleared", 32'(out_valid), 0);
        chk("t1_acc", 32'(last_acc), 255);
        chk("t1_cnt", 32'(last_cnt), 1);
        chk("t1_ovf", 32'(last_ovf), 0);

        // 2 and 3: back-to-back burst, then backpressure and accumulator clear
        out_ready = 1'b0;
        tick();
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b0);
        send(8'd7, 8'd8, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(out_valid), 1);
            chk("t3_hold_acc", 32'(acc_out), 98);
            chk("t3_hold_cnt", 32'(term_cnt), 3);
            chk("t3_hold_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        wait_drain();
        chk("t2_acc", 32'(last_acc), 98);
        send(8'd2, 8'd3, 1'b1);
        wait_drain();
        chk("t3_acc_cleared", 32'(last_acc), 6);

        // 4: wrap, sticky overflow and saturated count
        for (int i = 0; i < 259; i++) begin
            send(8'd255, 8'd255, 1'(i == 258));
        end
        wait_drain();
        chk("t4_acc", 32'(last_acc), 64259);
        chk("t4_cnt", 32'(last_cnt), 255);
        chk("t4_ovf", 32'(last_ovf), 1);
        send(8'd1, 8'd1, 1'b1);
        wait_drain();
        chk("t4_ovf_cleared", 32'(last_ovf), 0);
        chk("t4_next_acc", 32'(last_acc), 1);

        // 5: reset in the middle of a burst
        send(8'd9, 8'd9, 1'b0);
        send(8'd9, 8'd9, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_in_ready", 32'(in_ready), 0);
        chk("t5_rst_out_valid", 32'(out_valid), 0);
        tick();
        rst   = 1'b0;
        m_sum = 0;
        m_cnt = 0;
        @(negedge clk);
        chk("t5_in_ready", 32'(in_ready), 1);
        chk("t5_out_valid", 32'(out_valid), 0);
        tick();
        send(8'd2, 8'd3, 1'b1);
        wait_drain();
        chk("t5_acc", 32'(last_acc), 6);
        chk("t5_cnt", 32'(last_cnt), 1);

        // 6: random bursts with random input gaps and output backpressure
        rnd = 1'b1;
        for (int k = 0; k < 15; k++) begin
            int len;
            len = int'($urandom_range(1, 16));
            for (int j = 0; j < len; j++) begin
                repeat ($urandom_range(0, 2)) tick();
                send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'(j == len - 1));
            end
        end
        rnd       = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        chk("t6_results", 32'(n_pop), 32'(n_push));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
